// File: rtl/reco_run_sched.sv
// Round-robin scheduler sharing one seq_reco_d recorrelator between NUM_REQ bit-serial requesters.
// Optional: define RECO_RUN_SCHED_XY_EN to implement the cnt_xy coincidence counter.
module reco_run_sched #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned N_W      = 8,
    parameter int unsigned RECO_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*N_W-1:0] len,
    input  logic [NUM_REQ-1:0]     x_in,
    input  logic [NUM_REQ-1:0]     y_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     bit_en,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_REQ-1:0]     done_id,
    output logic [N_W-1:0]         cnt_x,
    output logic [N_W-1:0]         cnt_y,
    output logic [N_W-1:0]         cnt_xy,
    output logic                   reco_rst_n,
    output logic                   reco_x,
    output logic                   reco_y,
    input  logic                   reco_x_r,
    input  logic                   reco_y_r
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LAT_W = (RECO_LAT > 1) ? $clog2(RECO_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PTR_W-1:0]    ptr;
    logic [N_W-1:0]      rem;
    logic [LAT_W-1:0]    drain_cnt;
    logic [RECO_LAT-1:0] vld_sr;
    logic [N_W-1:0]      acc_x;
    logic [N_W-1:0]      acc_y;
    logic [N_W-1:0]      acc_x_nxt;
    logic [N_W-1:0]      acc_y_nxt;
    logic                smp;

    logic                found;
    logic [PTR_W-1:0]    idx;
    logic [PTR_W-1:0]    pick_nxt;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [N_W-1:0]      len_sel;
    logic [NUM_REQ-1:0]  gnt_nxt;

    // First requesting index at or after the pointer, wrapping.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        pick_nxt = '0;
        pick_oh  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((32'(ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                found        = 1'b1;
                pick_oh[idx] = 1'b1;
                pick_nxt     = PTR_W'((32'(ptr) + off + 32'd1) % NUM_REQ);
            end
        end
    end

    always_comb begin
        len_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) len_sel = len[i*N_W +: N_W];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and next grant.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = CLEAR;
                    gnt_nxt   = pick_oh;
                end
            end
            CLEAR:   state_nxt = (rem != '0) ? RUN : DONE;
            RUN:     if (rem == N_W'(1)) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // The recorrelator is flushed for the one CLEAR cycle and whenever we are in reset.
    assign reco_rst_n = rst_n & (state != CLEAR);
    assign reco_x     = |(x_in & bit_en);
    assign reco_y     = |(y_in & bit_en);

    assign smp       = vld_sr[RECO_LAT-1];
    assign acc_x_nxt = (state == CLEAR) ? '0 : acc_x + N_W'(smp & reco_x_r);
    assign acc_y_nxt = (state == CLEAR) ? '0 : acc_y + N_W'(smp & reco_y_r);

    // Job bookkeeping, sample window and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            rem       <= '0;
            drain_cnt <= '0;
            vld_sr    <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            gnt       <= '0;
            bit_en    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            cnt_x     <= '0;
            cnt_y     <= '0;
        end else begin
            gnt     <= gnt_nxt;
            bit_en  <= (state_nxt == RUN) ? gnt_nxt : '0;
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
            done_id <= (state_nxt == DONE) ? gnt_nxt : '0;

            if (state == IDLE && found) begin
                ptr <= pick_nxt;
                rem <= len_sel;
            end else if (state == RUN) begin
                rem <= rem - N_W'(1);
            end

            if (state == RUN && rem == N_W'(1)) drain_cnt <= LAT_W'(RECO_LAT - 1);
            else if (state == DRAIN)            drain_cnt <= drain_cnt - LAT_W'(1);

            vld_sr <= (vld_sr << 1) | RECO_LAT'(state == RUN);
            acc_x  <= acc_x_nxt;
            acc_y  <= acc_y_nxt;

            if (state_nxt == DONE) begin
                cnt_x <= acc_x_nxt;
                cnt_y <= acc_y_nxt;
            end
        end
    end

`ifdef RECO_RUN_SCHED_XY_EN
    logic [N_W-1:0] acc_xy;
    logic [N_W-1:0] acc_xy_nxt;

    assign acc_xy_nxt = (state == CLEAR) ? '0 : acc_xy + N_W'(smp & reco_x_r & reco_y_r);

    // Coincidence counter, same window as cnt_x/cnt_y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_xy <= '0;
            cnt_xy <= '0;
        end else begin
            acc_xy <= acc_xy_nxt;
            if (state_nxt == DONE) cnt_xy <= acc_xy_nxt;
        end
    end
`else
    assign cnt_xy = '0;
`endif

endmodule

// File: doc/reco_run_sched.md
Name: reco_run_sched

Overview:
- Round-robin scheduler that shares one seq_reco_d recorrelator instance between NUM_REQ bit-serial requesters.
- Per granted job:
  - clears the recorrelator's internal state;
  - streams the requester's x/y bits through it for a programmed length;
  - counts ones on the recorrelated outputs;
  - returns the counts with a one-cycle done pulse.
- Sits between stochastic-number generators / consumers and the recorrelator in the SC datapath.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- N_W, 8: width of job length and of each result counter.
- RECO_LAT, 1: cycles from recorrelator input to registered output (seq_reco_d is 1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester job request, level.
- len  in  NUM_REQ*N_W  per-requester stream length; slice i = len[i*N_W +: N_W].
- x_in  in  NUM_REQ  per-requester current x bit.
- y_in  in  NUM_REQ  per-requester current y bit.
- gnt  out  NUM_REQ  one-hot grant, held for the whole job.
- bit_en  out  NUM_REQ  one-hot strobe: granted requester advances to its next bit after this cycle.
- busy  out  1  scheduler not in IDLE.
- done  out  1  one-cycle pulse, job complete.
- done_id  out  NUM_REQ  one-hot owner of the completing job, valid with done.
- cnt_x  out  N_W  ones counted on reco_x_r for the last completed job.
- cnt_y  out  N_W  ones counted on reco_y_r.
- cnt_xy  out  N_W  cycles with reco_x_r & reco_y_r both 1.
- reco_rst_n  out  1  drives seq_reco_d rst_n.
- reco_x  out  1  drives seq_reco_d x.
- reco_y  out  1  drives seq_reco_d y.
- reco_x_r  in  1  from seq_reco_d x_reco_r.
- reco_y_r  in  1  from seq_reco_d y_reco_r.

Behaviour:
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- Reset (rst_n=0 at posedge, any state incl. mid-job):
  - state=IDLE; gnt=0, bit_en=0, busy=0, done=0, done_id=0;
  - cnt_x/cnt_y/cnt_xy=0; internal counters=0;
  - RR pointer=0 (requester 0 highest priority);
  - reco_rst_n=0 combinationally while rst_n=0.
- IDLE:
  - if req!=0, grant the first set bit at or after the pointer (wrapping);
  - latch len slice into remaining-count; go to CLEAR.
  - Pointer advances to granted index+1 mod NUM_REQ at grant.
- CLEAR (1 cycle):
  - reco_rst_n=0, flushing recorrelator state;
  - internal counters cleared;
  - next state RUN if latched len!=0, else DONE.
- RUN (exactly len cycles):
  - reco_x/reco_y = x_in/y_in of granted requester;
  - bit_en[g]=1; remaining-count decrements;
  - last cycle (remaining==1) goes to DRAIN.
- Outside RUN: reco_x=reco_y=0, bit_en=0.
- Sample window:
  - RUN-active delayed by RECO_LAT cycles through a valid shift register;
  - while delayed valid=1: cnt_x+=reco_x_r, cnt_y+=reco_y_r, cnt_xy+=reco_x_r&reco_y_r;
  - exactly len samples per job.
- DRAIN: RECO_LAT cycles, counting continues, then DONE.
- DONE (1 cycle):
  - done=1, done_id=gnt;
  - output count registers updated at the edge entering DONE and held until the next DONE;
  - next IDLE, gnt released on exit.
- Counters cannot overflow: len <= 2^N_W-1.
- req/len/x_in changes of non-granted requesters are ignored during a job.
- Granted requester deasserting req mid-job is ignored; the job completes.
- busy=1 in every non-IDLE state.
- Back-to-back: a new grant occurs the cycle after DONE at earliest (IDLE lasts ≥1 cycle).
- Job cycle count: 1 (CLEAR) + len + RECO_LAT + 1 (DONE).

Optional Feature:
- Macro: RECO_RUN_SCHED_XY_EN.
- Defined: cnt_xy counter implemented as above.
- Undefined: cnt_xy logic omitted; port tied to 0.
- cnt_x/cnt_y unaffected either way.

Test Plan:
- Reset mid-RUN → next cycle state IDLE, gnt=0, busy=0, cnt_*=0, reco_rst_n low during reset, no done.
- Single job, 1-cycle-delay recorrelator stub:
  - stimulus: req=2'b01, len0=8, x=10110010, y=11100000;
  - response: done after 11 cycles, done_id=01, cnt_x=4, cnt_y=3, cnt_xy=2 (0 with macro off).
- Real seq_reco_d DEPTH=1:
  - stimulus: len=4, x=1000, y=0001;
  - response: cnt_x=1, cnt_y=1, cnt_xy=1 (recorrelated overlap).
  - Follow-up: CLEAR pulse verified to wipe stored state between two jobs.
- Round-robin: req=2'b11 held, len0=len1=3 → grants alternate 01,10,01,10; done_id matches; no job starves.
- len=0 → CLEAR then DONE, bit_en never asserted, counts 0, done pulse 1 cycle.
- len=255 with x=y=all ones → cnt_x=cnt_y=cnt_xy=255, no wrap.
